dmem_ctrl: RTL and testbench

Parametrised data-memory controller, the successor to the word-only data RAM wrapper. It serves CPU loads and stores with byte, halfword and word size and sign/zero extension. It uses a valid/ready request handshake, registered read data and misalignment detection. A mode FSM arbitrates the memory between the CPU and the UART programmer. It sits between the MEM stage (address from ALU result, store data from decoder read_data_2) and an internal inferred RAM array.

---
 rtl/dmem_pkg.sv | 68 ++++++
 rtl/dmem_bram.sv | 45 ++++
 rtl/dmem_ctrl.sv | 153 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory controller.
//   - access size encodings (byte / half / word; 2'b11 behaves as word)
//   - mode FSM state enum
//   - helpers for misalignment detection, byte-enable generation,
//     store-data lane replication and load extension (32-bit words only)
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // PROG : UART programmer owns the array
   // RUN  : CPU requests accepted
   // DRAIN: CPU lost the array but one response is still owed
   typedef enum logic [1:0] {
      ST_PROG  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      logic res;
      case (size)
         SZ_BYTE: res = 1'b0;
         SZ_HALF: res = lo[0];
         default: res = (lo != 2'b00);   // word and reserved size
      endcase
      return res;
   endfunction

   function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lo);
      logic [3:0] be;
      case (size)
         SZ_BYTE: be = 4'b0001 << lo;
         SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Store data arrives right-aligned; copy it into every lane so the byte
   // enables alone decide which bytes land in the array.
   function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] data);
      logic [31:0] res;
      case (size)
         SZ_BYTE: res = {4{data[7:0]}};
         SZ_HALF: res = {2{data[15:0]}};
         default: res = data;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lo,
                                               input logic [1:0] size, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b = word[{lo, 3'b000} +: 8];
      h = lo[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: res = {{24{b[7] & ~uns}}, b};
         SZ_HALF: res = {{16{h[15] & ~uns}}, h};
         default: res = word;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/dmem_bram.sv
// dmem_bram: single-port, 4-lane byte-enable RAM, written for block-RAM
// inference. Read data is registered; on a write the registered output
// shows the newly written bytes (write-first), unwritten lanes show the
// stored bytes.
// Ports:
//   clk   - clock
//   en    - access enable (read and/or write this edge)
//   we    - per-lane write enables
//   adr   - word address
//   wdata - write data (lane i = wdata[8i+7:8i])
//   rdata - registered read data
module dmem_bram #(
  parameter int    ADDR_W    = 12,
  parameter int    DEPTH     = 4096,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] adr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  // The array starts zero-filled at elaboration.
  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = '0;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[adr][i*8 +: 8] <= wdata[i*8 +: 8];
          rdata[i*8 +: 8]    <= wdata[i*8 +: 8];
        end else begin
          rdata[i*8 +: 8]    <= mem[adr][i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller between the MEM stage and an internal
// RAM. Serves byte/half/word loads and stores with sign/zero extension,
// detects misalignment, and hands the array between the CPU and the UART
// programmer through a PROG/RUN/DRAIN mode FSM.
// Ports:
//   ram_clk_i, ram_rst_n_i           - clock, async active-low reset
//   req_valid_i / req_ready_o        - CPU request handshake
//   req_we_i, req_size_i, req_unsigned_i, ram_adr_i, ram_dat_i - request fields
//   ram_dat_o, rsp_valid_o, misalign_o - one-cycle response after accept
//   upg_rst_i, upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i - UART programmer
//   prog_mode_o                      - 1 while the programmer owns the array
//   fsm_state                        - current mode FSM state (debug)
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both 1; exactly one rsp_valid_o pulse follows on the next
// cycle for every transfer, unless reset intervenes. req_ready_o depends
// only on state, never on req_valid_i.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int    ADDR_W    = 14,
   parameter int    DATA_W    = 32,
   parameter int    DEPTH     = 4096,   // must equal 2**(ADDR_W-2)
   parameter string INIT_FILE = ""
) (
   input  logic              ram_clk_i,
   input  logic              ram_rst_n_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_unsigned_i,
   input  logic [ADDR_W-1:0] ram_adr_i,
   input  logic [DATA_W-1:0] ram_dat_i,
   output logic [DATA_W-1:0] ram_dat_o,
   output logic              rsp_valid_o,
   output logic              misalign_o,
   input  logic              upg_rst_i,
   input  logic              upg_wen_i,
   input  logic [ADDR_W-3:0] upg_adr_i,
   input  logic [DATA_W-1:0] upg_dat_i,
   input  logic              upg_done_i,
   output logic              prog_mode_o,
   output logic [1:0]        fsm_state
);

   localparam int WORD_W = ADDR_W - 2;

   state_t state, state_next;

   logic              kick;
   logic              accept;
   logic              mis;

   logic              ram_en;
   logic [3:0]        ram_we;
   logic [WORD_W-1:0] ram_adr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   // Response pipeline: what the accepted request was, for the next cycle.
   logic              load_q;
   logic [1:0]        rd_lo_q;
   logic [1:0]        rd_size_q;
   logic              rd_uns_q;
   logic [31:0]       hold_q;     // last value shown on ram_dat_o

   assign kick        = upg_rst_i | upg_done_i;
   assign req_ready_o = (state == ST_RUN);
   assign prog_mode_o = (state == ST_PROG);
   assign fsm_state   = state;
   assign accept      = req_valid_i & req_ready_o;
   assign mis         = is_misaligned(req_size_i, ram_adr_i[1:0]);

   // ---------------- mode FSM ----------------
   always_ff @(posedge ram_clk_i or negedge ram_rst_n_i) begin
      if (!ram_rst_n_i) state <= ST_PROG;
      else              state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_PROG:  if (kick) state_next = ST_RUN;
         // A request accepted on the same edge kick drops still owes a
         // response, so pass through DRAIN to deliver it.
         ST_RUN:   if (!kick) state_next = accept ? ST_DRAIN : ST_PROG;
         ST_DRAIN: state_next = ST_PROG;
         default:  state_next = ST_PROG;
      endcase
   end

   // ---------------- array port mux ----------------
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 4'b0000;
      ram_adr   = ram_adr_i[ADDR_W-1:2];   // word index wraps modulo DEPTH
      ram_wdata = store_data(req_size_i, ram_dat_i);
      if (state == ST_PROG) begin
         ram_en    = upg_wen_i;
         ram_we    = {4{upg_wen_i}};
         ram_adr   = upg_adr_i;
         ram_wdata = upg_dat_i;
      end else if (accept && !mis) begin
         ram_en = 1'b1;
         ram_we = req_we_i ? byte_enable(req_size_i, ram_adr_i[1:0]) : 4'b0000;
      end
   end

   dmem_bram #(
      .ADDR_W   (WORD_W),
      .DEPTH    (DEPTH),
      .INIT_FILE(INIT_FILE)
   ) u_bram (
      .clk  (ram_clk_i),
      .en   (ram_en),
      .we   (ram_we),
      .adr  (ram_adr),
      .wdata(ram_wdata),
      .rdata(ram_rdata)
   );

   // ---------------- response registers ----------------
   always_ff @(posedge ram_clk_i or negedge ram_rst_n_i) begin
      if (!ram_rst_n_i) begin
         rsp_valid_o <= 1'b0;
         misalign_o  <= 1'b0;
         load_q      <= 1'b0;
         rd_lo_q     <= 2'b00;
         rd_size_q   <= SZ_WORD;
         rd_uns_q    <= 1'b0;
         hold_q      <= '0;
      end else begin
         rsp_valid_o <= accept;
         misalign_o  <= accept & mis;
         load_q      <= accept & ~mis & ~req_we_i;
         if (accept) begin
            rd_lo_q   <= ram_adr_i[1:0];
            rd_size_q <= req_size_i;
            rd_uns_q  <= req_unsigned_i;
         end
         hold_q      <= ram_dat_o;
      end
   end

   // Loads show the extended array word; a rejected access forces zero;
   // otherwise (stores, idle) the previous value is held.
   always_comb begin
      ram_dat_o = hold_q;
      if (load_q)          ram_dat_o = load_extend(ram_rdata, rd_lo_q, rd_size_q, rd_uns_q);
      else if (misalign_o) ram_dat_o = '0;
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;
   import dmem_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [1:0]  req_size_i = 2'b00;
   logic        req_unsigned_i = 1'b0;
   logic [13:0] ram_adr_i = '0;
   logic [31:0] ram_dat_i = '0;
   logic [31:0] ram_dat_o;
   logic        rsp_valid_o;
   logic        misalign_o;
   logic        upg_rst_i = 1'b0;
   logic        upg_wen_i = 1'b0;
   logic [11:0] upg_adr_i = '0;
   logic [31:0] upg_dat_i = '0;
   logic        upg_done_i = 1'b0;
   logic        prog_mode_o;
   logic [1:0]  fsm_state;

   int compared = 0;
   int mismatched = 0;
   int cycle = 0;
   int last_rsp = -10;
   int prev_rsp = -10;

   // {misalign, data}
   logic [32:0] exp_q[$];

   dmem_ctrl #(.ADDR_W(14), .DATA_W(32), .DEPTH(4096), .INIT_FILE("")) dut (
      .ram_clk_i     (clk),
      .ram_rst_n_i   (rst_n),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_we_i      (req_we_i),
      .req_size_i    (req_size_i),
      .req_unsigned_i(req_unsigned_i),
      .ram_adr_i     (ram_adr_i),
      .ram_dat_i     (ram_dat_i),
      .ram_dat_o     (ram_dat_o),
      .rsp_valid_o   (rsp_valid_o),
      .misalign_o    (misalign_o),
      .upg_rst_i     (upg_rst_i),
      .upg_wen_i     (upg_wen_i),
      .upg_adr_i     (upg_adr_i),
      .upg_dat_i     (upg_dat_i),
      .upg_done_i    (upg_done_i),
      .prog_mode_o   (prog_mode_o),
      .fsm_state     (fsm_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called #1 after a rising edge while the DUT is in RUN.
   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [13:0] adr, input logic [31:0] dat,
                         input logic exp_mis, input logic [31:0] exp_dat);
      req_valid_i    = 1'b1;
      req_we_i       = we;
      req_size_i     = size;
      req_unsigned_i = uns;
      ram_adr_i      = adr;
      ram_dat_i      = dat;
      exp_q.push_back({exp_mis, exp_dat});
      @(posedge clk); #1;
      req_valid_i    = 1'b0;
   endtask

   task automatic prog_write(input logic [11:0] adr, input logic [31:0] dat);
      upg_wen_i = 1'b1;
      upg_adr_i = adr;
      upg_dat_i = dat;
      @(posedge clk); #1;
      upg_wen_i = 1'b0;
   endtask

   // ---------------- scoreboard monitor ----------------
   initial begin
      logic [32:0] e;
      forever begin
         @(negedge clk);
         cycle++;
         if (rst_n && rsp_valid_o) begin
            if (exp_q.size() == 0) begin
               check("unexpected_rsp", {misalign_o, ram_dat_o}, 33'h1_FFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("rsp", {misalign_o, ram_dat_o}, e);
            end
            prev_rsp = last_rsp;
            last_rsp = cycle;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      // Reset state
      #12;
      check("rst_ready",   {32'd0, req_ready_o}, 33'd0);
      check("rst_rsp",     {31'd0, rsp_valid_o, misalign_o}, 33'd0);
      check("rst_dat",     {1'b0, ram_dat_o}, 33'd0);
      check("rst_prog",    {32'd0, prog_mode_o}, 33'd1);
      check("rst_state",   {31'd0, fsm_state}, {31'd0, ST_PROG});
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Programming phase
      prog_write(12'd3, 32'hDEADBEEF);
      prog_write(12'd0, 32'h11223344);
      check("prog_mode_before_done", {32'd0, prog_mode_o}, 33'd1);
      upg_done_i = 1'b1;
      @(posedge clk); #1;
      check("prog_mode_after_done", {32'd0, prog_mode_o}, 33'd0);
      check("ready_in_run",         {32'd0, req_ready_o}, 33'd1);

      //      we    size     uns   adr       data          mis   expected
      do_req(1'b0, SZ_WORD, 1'b0, 14'h00C, 32'h0,        1'b0, 32'hDEADBEEF);
      do_req(1'b1, SZ_BYTE, 1'b0, 14'h00D, 32'h00000080, 1'b0, 32'hDEADBEEF);
      do_req(1'b0, SZ_BYTE, 1'b0, 14'h00D, 32'h0,        1'b0, 32'hFFFFFF80);
      do_req(1'b0, SZ_BYTE, 1'b1, 14'h00D, 32'h0,        1'b0, 32'h00000080);
      do_req(1'b1, SZ_HALF, 1'b0, 14'h00E, 32'h00001234, 1'b0, 32'h00000080);
      do_req(1'b0, SZ_HALF, 1'b0, 14'h00E, 32'h0,        1'b0, 32'h00001234);
      do_req(1'b0, SZ_WORD, 1'b0, 14'h00C, 32'h0,        1'b0, 32'h123480EF);
      do_req(1'b0, SZ_HALF, 1'b0, 14'h00C, 32'h0,        1'b0, 32'hFFFF80EF);
      do_req(1'b0, SZ_HALF, 1'b1, 14'h00C, 32'h0,        1'b0, 32'h000080EF);
      do_req(1'b0, SZ_BYTE, 1'b0, 14'h00F, 32'h0,        1'b0, 32'h00000012);
      do_req(1'b0, SZ_WORD, 1'b0, 14'h002, 32'h0,        1'b1, 32'h00000000);
      do_req(1'b1, SZ_HALF, 1'b0, 14'h001, 32'h00005555, 1'b1, 32'h00000000);
      do_req(1'b0, SZ_WORD, 1'b0, 14'h000, 32'h0,        1'b0, 32'h11223344);
      do_req(1'b1, SZ_WORD, 1'b0, 14'h020, 32'hA5A5A5A5, 1'b0, 32'h11223344);
      do_req(1'b0, SZ_WORD, 1'b0, 14'h020, 32'h0,        1'b0, 32'hA5A5A5A5);
      @(posedge clk); #1;
      check("b2b_consecutive_rsp", {1'b0, 32'(last_rsp - prev_rsp)}, 33'd1);
      do_req(1'b1, SZ_BYTE, 1'b0, 14'h022, 32'h0000005A, 1'b0, 32'hA5A5A5A5);
      do_req(1'b0, 2'b11,   1'b0, 14'h020, 32'h0,        1'b0, 32'hA55AA5A5);
      do_req(1'b0, SZ_BYTE, 1'b1, 14'h023, 32'h0,        1'b0, 32'h000000A5);
      do_req(1'b0, SZ_BYTE, 1'b0, 14'h022, 32'h0,        1'b0, 32'h0000005A);
      @(posedge clk); #1;

      // Kick drops on the same edge a load is accepted -> DRAIN
      upg_done_i = 1'b0;
      do_req(1'b0, SZ_WORD, 1'b0, 14'h00C, 32'h0, 1'b0, 32'h123480EF);
      check("drain_state", {31'd0, fsm_state}, {31'd0, ST_DRAIN});
      check("drain_ready", {32'd0, req_ready_o}, 33'd0);
      check("drain_prog",  {32'd0, prog_mode_o}, 33'd0);
      @(posedge clk); #1;
      check("after_drain_state", {31'd0, fsm_state}, {31'd0, ST_PROG});
      check("after_drain_rsp",   {32'd0, rsp_valid_o}, 33'd0);
      prog_write(12'd3, 32'hCAFEF00D);
      upg_done_i = 1'b1;
      @(posedge clk); #1;
      // Programmer write in RUN must be ignored
      upg_wen_i = 1'b1;
      upg_adr_i = 12'd3;
      upg_dat_i = 32'h0;
      do_req(1'b0, SZ_WORD, 1'b0, 14'h00C, 32'h0, 1'b0, 32'hCAFEF00D);
      upg_wen_i = 1'b0;
      do_req(1'b0, SZ_WORD, 1'b0, 14'h00C, 32'h0, 1'b0, 32'hCAFEF00D);
      @(posedge clk); #1;

      // Async reset while a load response is pending
      req_valid_i = 1'b1;
      req_we_i    = 1'b0;
      req_size_i  = SZ_WORD;
      ram_adr_i   = 14'h00C;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_rsp",   {31'd0, rsp_valid_o, misalign_o}, 33'd0);
      check("midrst_dat",   {1'b0, ram_dat_o}, 33'd0);
      check("midrst_ready", {32'd0, req_ready_o}, 33'd0);
      check("midrst_prog",  {32'd0, prog_mode_o}, 33'd1);
      @(posedge clk); #1;
      upg_done_i = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_no_rsp", {32'd0, rsp_valid_o}, 33'd0);
      check("queue_drained",   {1'b0, 32'(exp_q.size())}, 33'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
